// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and its neighbours: FSM state
// encoding, instruction field positions and the branch opcodes that the
// branch logic decodes from the word this unit issues.
package pc_fetch_unit_pkg;

  // Fetch sequencer states; HALT is absorbing until reset.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // Instruction word layout.
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int IMM_W   = 16;

  // Branch opcodes, kept here so fetch, decode and branch logic agree.
  localparam logic [OPC_W-1:0] OPC_BZ   = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_BCY  = 5'b01110;
  localparam logic [OPC_W-1:0] OPC_BNCY = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_BLTZ = 5'b10000;

  // Extract the opcode field from an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  // True when the opcode is one of the conditional branches.
  function automatic logic is_branch_opcode(input logic [OPC_W-1:0] opc);
    return (opc == OPC_BZ) || (opc == OPC_BCY) ||
           (opc == OPC_BNCY) || (opc == OPC_BLTZ);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction memory request/acknowledge bus. The fetch unit is the master:
// it raises imem_req with imem_addr and holds both until the memory returns
// imem_ack together with imem_data, so memory latency may vary freely.
interface pc_fetch_unit_if #(
  parameter int PC_W = 10
);
  import pc_fetch_unit_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/pc_fetch_unit_imm_sign_ext.sv
// 16 -> 32 bit sign extension of the immediate field. Kept as its own block
// because decode and the ALU operand path use the same extension.
module pc_fetch_unit_imm_sign_ext
  import pc_fetch_unit_pkg::*;
(
  input  logic [IMM_W-1:0]   imm_in,
  output logic [INSTR_W-1:0] imm_out
);

  assign imm_out = {{(INSTR_W - IMM_W){imm_in[IMM_W-1]}}, imm_in};

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer. Fetches one word at a
// time from instruction memory, holds it issued until the core retires it,
// then takes the next PC from branch logic. Stops in a sticky HALT state
// after the last program address retires, or when branch logic asks for an
// address beyond the end of instruction memory (flagged as a fault).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int RESET_PC   = 0,
  parameter int END_PC     = 59,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_W-1:0]     npc,
  input  logic                exec_done,
  pc_fetch_unit_if.master     bus,
  output logic [PC_W-1:0]     pc,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [INSTR_W-1:0]  imm,
  output logic                instr_valid,
  output logic                halted,
  output logic                fault
);

  // Parameters resized once so every comparison below is width-matched.
  // The range check is done at 32 bits so that IMEM_DEPTH == 2**PC_W
  // (every address valid) works without overflow.
  localparam logic [PC_W-1:0]    RESET_PC_L   = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]    END_PC_L     = PC_W'(END_PC);
  localparam logic [31:0]        IMEM_DEPTH_L = 32'(IMEM_DEPTH);

  fetch_state_t state;
  logic         req_q;
  logic [31:0]  npc_ext;
  logic         npc_out_of_range;

  assign npc_ext          = {{(32 - PC_W){1'b0}}, npc};
  assign npc_out_of_range = (npc_ext >= IMEM_DEPTH_L);

  // The PC is never changed while a request is outstanding, so the fetch
  // address can simply follow it.
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc;

  // Decoded fields follow the latched word and therefore stay stable for
  // the whole time the instruction is issued.
  assign opcode = opcode_of(instr);

  pc_fetch_unit_imm_sign_ext u_imm_sign_ext (
    .imm_in  (instr[IMM_W-1:0]),
    .imm_out (imm)
  );

  // Fetch sequencer: state, PC, latched instruction and all status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC_L;
      instr       <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          req_q <= 1'b1;
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bus.imem_ack) begin
            instr       <= bus.imem_data;
            req_q       <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            if (pc == END_PC_L) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else if (npc_out_of_range) begin
              halted <= 1'b1;
              fault  <= 1'b1;
              state  <= ST_HALT;
            end else begin
              pc    <= npc;
              state <= ST_FETCH;
            end
          end
        end

        ST_HALT: begin
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end

        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule
